// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver. Each digit slot opens with a short
// all-off dead time; new display content is applied only at frame boundaries.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {BLANK, SHOW} state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d, shd_data_q, shd_data_d;
  logic [7:0]    act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic [7:0]    act_en_q, act_en_d, shd_en_q, shd_en_d;
  logic          pend_q, pend_d, fdone_q, fdone_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          boundary;
  logic [3:0]    nib;
  state_e        state;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state    = (32'(cnt_q) < 32'(BLANK_CYC)) ? BLANK : SHOW;
    boundary = (cnt_q == LAST) && (idx_q == 3'd7);
    nib      = act_data_q[{idx_q, 2'b00} +: 4];

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end

    act_data_d = act_data_q; act_dp_d = act_dp_q; act_en_d = act_en_q;
    shd_data_d = shd_data_q; shd_dp_d = shd_dp_q; shd_en_d = shd_en_q;
    pend_d     = pend_q;
    fdone_d    = boundary;
    // A load landing on the boundary itself bypasses the shadow entirely.
    if (boundary) begin
      pend_d = 1'b0;
      if (load) begin
        act_data_d = data_in; act_dp_d = dp_in; act_en_d = en_in;
      end else if (pend_q) begin
        act_data_d = shd_data_q; act_dp_d = shd_dp_q; act_en_d = shd_en_q;
      end
    end else if (load) begin
      shd_data_d = data_in; shd_dp_d = dp_in; shd_en_d = en_in;
      pend_d     = 1'b1;
    end

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state == SHOW && act_en_q[idx_q]) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_data_q <= '0; act_dp_q <= '0; act_en_q <= '0;
      shd_data_q <= '0; shd_dp_q <= '0; shd_en_q <= '0;
      pend_q     <= 1'b0;
      fdone_q    <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d; act_dp_q <= act_dp_d; act_en_q <= act_en_d;
      shd_data_q <= shd_data_d; shd_dp_q <= shd_dp_d; shd_en_q <= shd_en_d;
      pend_q     <= pend_d;
      fdone_q    <= fdone_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign pending    = pend_q;
  assign frame_done = fdone_q;
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100_000, clock cycles per digit slot (1 ms @ 100 MHz); legal range 2..2^21-1.
REQ-002 SHALL provide parameter BLANK_CYC, default 1_000, all-off dead-time cycles at the start of each slot (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  32  eight hex nibbles; digit i = data_in[4i+3:4i].
REQ-006 dp_in  input  8  decimal point request per digit, 1 = lit.
REQ-007 en_in  input  8  digit enable mask, 1 = digit shown, 0 = digit dark.
REQ-008 load  input  1  single-cycle request to capture data_in/dp_in/en_in.
REQ-009 an  output  8  digit anodes, active-low, an[i] drives digit i.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point segment, active-low.
REQ-012 pending  output  1  high while a captured load awaits the next frame boundary.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-014 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap; digit index idx SHALL advance on wrap, 7 -> 0.
REQ-015 Per slot, state BLANK while cnt < BLANK_CYC, state SHOW otherwise; no other states.
REQ-016 an, seg, dp SHALL be registered and reflect the cnt/idx/state of the previous cycle (1-cycle latency).
REQ-017 In BLANK: an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-018 In SHOW with active-register bit en[idx] = 1: an = ~(1 << idx), seg = hex decode of nibble idx, dp = ~dpr[idx]; with en[idx] = 0: as BLANK.
REQ-019 Hex decode SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex, seg[6:0]).
REQ-020 load = 1 SHALL copy data_in/dp_in/en_in into a shadow register and set pending, except in the boundary cycle (REQ-022).
REQ-021 A load while pending = 1 SHALL overwrite the shadow; only the newest load is applied.
REQ-022 Frame boundary cycle = (cnt == SCAN_DIV-1 and idx == 7); on its edge active registers SHALL take the inputs directly if load = 1, else the shadow if pending = 1, else hold; pending SHALL clear.
REQ-023 Active registers SHALL change only at frame boundaries; no mid-frame tearing.
REQ-024 frame_done SHALL be high for exactly the one cycle following the boundary edge.
REQ-025 Display output SHALL never drive more than one an bit low in any cycle.

Reset
REQ-026 rst = 1 at a clock edge SHALL set cnt = 0, idx = 0, state BLANK, active and shadow data/dp/en = 0, pending = 0, frame_done = 0, an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-027 rst SHALL take priority over load and boundary events; reset mid-frame discards pending data and restarts at digit 0, cnt 0.
REQ-028 After rst deasserts, the display SHALL stay dark until the first boundary that applies a load (en = 0).

Verification (SCAN_DIV = 8, BLANK_CYC = 2)
REQ-029 Reset, then idle 64 cycles -> an = FF, seg = 7F, dp = 1 throughout; frame_done pulses every 64 cycles, first in cycle 64 after reset release.
REQ-030 load data_in = 32'h76543210, dp_in = 8'h01, en_in = 8'hFF at cycle 3 -> pending = 1 until boundary; next frame digit 0 shows an = FE, seg = 40, dp = 0 for cnt 2..7 (lagged 1), digit 5 shows seg = 12; pending = 0.
REQ-031 Two loads in one frame (32'h11111111 then 32'h22222222) -> only 2 appears next frame (seg = 24); 1 never displayed.
REQ-032 load in the boundary cycle with 32'hFFFFFFFF while shadow holds 32'h0 -> next frame shows F (seg = 0E), pending = 0 afterwards.
REQ-033 en_in = 8'b1010_1010 -> an bits 0,2,4,6 never go low; slots still consume 8 cycles each; BLANK cycles all-off.
REQ-034 rst pulse during digit 4 with pending = 1 -> outputs dark next cycle, pending = 0, scan restarts at digit 0, shadow data never displayed.
